// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and default sizes for the SRAM arbiter.
//   arb_state_e : access FSM state (IDLE, ACCESS)
//   arb_port_e  : requester select (PORT_A = hash core, PORT_B = host)
package sram_arb_pkg;

  localparam int unsigned SRAM_ARB_ADDR_BITS = 6;
  localparam int unsigned SRAM_ARB_DATA_BITS = 128;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_e;

endpackage

// File: rtl/sram_arb_sel.sv
// sram_arb_sel: combinational winner selection between requesters A and B.
// Optional feature macro: SRAM_ARB_RR_EN
//   defined   -> round-robin; on a tie the port not granted most recently wins
//   undefined -> fixed priority, A wins every tie; no pointer register
// Ports:
//   clk_i, n_rst_i   : clock, synchronous active-low reset
//   req_a_i, req_b_i : requests
//   gnt_a_o, gnt_b_o : combinational grants (forced low while in reset)
//   win_o            : granted port (valid when either grant is high)
module sram_arb_sel
  import sram_arb_pkg::*;
(
  input  logic      clk_i,
  input  logic      n_rst_i,
  input  logic      req_a_i,
  input  logic      req_b_i,
  output logic      gnt_a_o,
  output logic      gnt_b_o,
  output arb_port_e win_o
);

`ifdef SRAM_ARB_RR_EN
  // prio_q names the port that wins the next tie; it moves only on a grant.
  arb_port_e prio_q;
  arb_port_e prio_d;

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (n_rst_i) begin
      if (req_a_i && (!req_b_i || prio_q == PORT_A)) begin
        gnt_a_o = 1'b1;
      end else if (req_b_i) begin
        gnt_b_o = 1'b1;
      end
    end
    prio_d = prio_q;
    if (gnt_a_o) begin
      prio_d = PORT_B;
    end else if (gnt_b_o) begin
      prio_d = PORT_A;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      prio_q <= PORT_A;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clk_i;

  always_comb begin
    gnt_a_o = n_rst_i && req_a_i;
    gnt_b_o = n_rst_i && req_b_i && !req_a_i;
  end
`endif

  assign win_o = gnt_b_o ? PORT_B : PORT_A;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter in front of a single-port SRAM.
// Optional feature macro: SRAM_ARB_RR_EN (round-robin instead of A-priority).
// Ports:
//   clk, n_rst                       : clock, synchronous active-low reset
//   req/we/addr/wdata_{a,b}          : requests (held until gnt seen)
//   gnt_{a,b}                        : combinational grant pulse
//   rvalid_{a,b}, rdata_{a,b}        : read return, 2 cycles after gnt
//   read_enable, write_enable,
//   address, write_data, read_data   : SRAM side, one access per cycle
//   busy                             : high while an access is in flight
// Timing: grant cycle -> access cycle (enables driven) -> read data
// captured at the end of the access cycle and flagged with rvalid.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = SRAM_ARB_ADDR_BITS,
  parameter int unsigned DATA_BITS = SRAM_ARB_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 req_a,
  input  logic                 we_a,
  input  logic [ADDR_BITS-1:0] addr_a,
  input  logic [DATA_BITS-1:0] wdata_a,
  output logic                 gnt_a,
  output logic                 rvalid_a,
  output logic [DATA_BITS-1:0] rdata_a,
  input  logic                 req_b,
  input  logic                 we_b,
  input  logic [ADDR_BITS-1:0] addr_b,
  input  logic [DATA_BITS-1:0] wdata_b,
  output logic                 gnt_b,
  output logic                 rvalid_b,
  output logic [DATA_BITS-1:0] rdata_b,
  output logic                 read_enable,
  output logic                 write_enable,
  output logic [ADDR_BITS-1:0] address,
  output logic [DATA_BITS-1:0] write_data,
  input  logic [DATA_BITS-1:0] read_data,
  output logic                 busy
);

  arb_port_e            win;
  logic                 gnt_any;
  logic                 sel_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;

  arb_state_e           state_q;
  arb_port_e            port_q;
  logic                 re_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic                 rvalid_a_q;
  logic                 rvalid_b_q;
  logic [DATA_BITS-1:0] rdata_a_q;
  logic [DATA_BITS-1:0] rdata_b_q;

  sram_arb_sel u_sel (
    .clk_i   (clk),
    .n_rst_i (n_rst),
    .req_a_i (req_a),
    .req_b_i (req_b),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b),
    .win_o   (win)
  );

  assign gnt_any = gnt_a | gnt_b;

  always_comb begin
    sel_we    = we_a;
    sel_addr  = addr_a;
    sel_wdata = wdata_a;
    if (win == PORT_B) begin
      sel_we    = we_b;
      sel_addr  = addr_b;
      sel_wdata = wdata_b;
    end
  end

  // A grant in any state starts an access next cycle, which is what lets a
  // grant in the access cycle sustain one access per cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      port_q     <= PORT_A;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      if (gnt_any) begin
        state_q <= ACCESS;
        port_q  <= win;
        re_q    <= !sel_we;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_we ? sel_wdata : '0;
      end else begin
        state_q <= IDLE;
        re_q    <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
      end

      rvalid_a_q <= re_q && (port_q == PORT_A);
      rvalid_b_q <= re_q && (port_q == PORT_B);
      if (re_q && (port_q == PORT_A)) begin
        rdata_a_q <= read_data;
      end
      if (re_q && (port_q == PORT_B)) begin
        rdata_b_q <= read_data;
      end
    end
  end

  assign read_enable  = re_q;
  assign write_enable = we_q;
  assign address      = addr_q;
  assign write_data   = wdata_q;
  assign rvalid_a     = rvalid_a_q;
  assign rvalid_b     = rvalid_b_q;
  assign rdata_a      = rdata_a_q;
  assign rdata_b      = rdata_b_q;
  assign busy         = (state_q == ACCESS);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter with a behavioural
// SRAM and a transaction-level reference model for the randomized run.
// Build with or without SRAM_ARB_RR_EN; expectations follow the macro.
module tb_sram_arbiter;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         req_a, we_a, req_b, we_b;
  logic [5:0]   addr_a, addr_b;
  logic [127:0] wdata_a, wdata_b;
  logic         gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [127:0] rdata_a, rdata_b;
  logic         read_enable, write_enable, busy;
  logic [5:0]   address;
  logic [127:0] write_data, read_data;

  int total = 0;
  int bad   = 0;

  // behavioural SRAM, with a bench-side preload port
  logic [127:0] sram_mem [64];
  logic         pre_en = 1'b0;
  logic [5:0]   pre_addr = '0;
  logic [127:0] pre_data = '0;
  logic [127:0] ref_mem [8];

  assign read_data = read_enable ? sram_mem[address] : 128'd0;

  always @(posedge clk) begin
    if (pre_en) sram_mem[pre_addr] <= pre_data;
    else if (write_enable) sram_mem[address] <= write_data;
  end

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_BITS(6), .DATA_BITS(128)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data),
    .busy(busy)
  );

  // the two enables must never be high together, in any scenario
  always @(negedge clk) begin
    total++;
    if (read_enable === 1'b1 && write_enable === 1'b1) begin
      bad++;
      $display("FAIL enable_overlap t=%0t: read_enable=%b write_enable=%b required not both 1",
               $time, read_enable, write_enable);
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    n_rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [127:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    total++;
    if ({read_enable, write_enable, busy, rvalid_a, rvalid_b} !== 5'b0 ||
        address !== 6'd0 || write_data !== 128'd0 || rdata_a !== 128'd0 || rdata_b !== 128'd0) begin
      bad++;
      $display("FAIL reset_outputs: re=%b we=%b busy=%b rv_a=%b rv_b=%b addr=%h wd=%h rd_a=%h rd_b=%h required all 0",
               read_enable, write_enable, busy, rvalid_a, rvalid_b, address, write_data, rdata_a, rdata_b);
    end
    total++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_gnt: gnt_a=%b gnt_b=%b required 0 0", gnt_a, gnt_b);
    end
    @(posedge clk); #1;
    n_rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_single_write();
    logic [127:0] d;
    d = 128'haaccddbbeeff00112233445566778899;
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'h16; wdata_a = d;
    #3;
    total++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      bad++;
      $display("FAIL write_gnt: gnt_a=%b gnt_b=%b required 1 0", gnt_a, gnt_b);
    end
    @(posedge clk); #1;
    req_a = 1'b0;
    #3;
    total++;
    if (write_enable !== 1'b1 || read_enable !== 1'b0 || address !== 6'h16 || write_data !== d) begin
      bad++;
      $display("FAIL write_access: we=%b re=%b addr=%h wd=%h required 1 0 16 %h",
               write_enable, read_enable, address, write_data, d);
    end
    @(posedge clk); #4;
    total++;
    if (write_enable !== 1'b0 || busy !== 1'b0 || address !== 6'd0 || write_data !== 128'd0) begin
      bad++;
      $display("FAIL write_after: we=%b busy=%b addr=%h wd=%h required 0 0 0 0",
               write_enable, busy, address, write_data);
    end
  endtask

  task automatic test_read_back();
    logic [127:0] d;
    d = 128'haaccddbbeeff00112233445566778899;
    @(posedge clk); #1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'h16; wdata_b = 128'd0;
    #3;
    total++;
    if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
      bad++;
      $display("FAIL read_gnt: gnt_b=%b gnt_a=%b required 1 0", gnt_b, gnt_a);
    end
    @(posedge clk); #1;
    req_b = 1'b0;
    #3;
    total++;
    if (read_enable !== 1'b1 || write_enable !== 1'b0 || address !== 6'h16 || rvalid_b !== 1'b0) begin
      bad++;
      $display("FAIL read_access: re=%b we=%b addr=%h rv_b=%b required 1 0 16 0",
               read_enable, write_enable, address, rvalid_b);
    end
    @(posedge clk); #4;
    total++;
    if (rvalid_b !== 1'b1 || rdata_b !== d || rvalid_a !== 1'b0) begin
      bad++;
      $display("FAIL read_return: rv_b=%b rd_b=%h rv_a=%b required 1 %h 0", rvalid_b, rdata_b, rvalid_a, d);
    end
    @(posedge clk); #4;
    total++;
    if (rvalid_b !== 1'b0 || rdata_b !== d) begin
      bad++;
      $display("FAIL read_hold: rv_b=%b rd_b=%h required 0 %h", rvalid_b, rdata_b, d);
    end
  endtask

  task automatic test_contention();
    logic exp_a;
    int   b_count;
    b_count = 0;
    do_reset();
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'd2;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      #3;
`ifdef SRAM_ARB_RR_EN
      exp_a = (i % 2 == 0);
`else
      exp_a = 1'b1;
`endif
      if (gnt_b === 1'b1) b_count++;
      total++;
      if (gnt_a !== exp_a || gnt_b !== !exp_a) begin
        bad++;
        $display("FAIL contention_gnt cycle %0d: gnt_a=%b gnt_b=%b required %b %b",
                 i, gnt_a, gnt_b, exp_a, !exp_a);
      end
    end
    total++;
`ifdef SRAM_ARB_RR_EN
    if (b_count != 2) begin
`else
    if (b_count != 0) begin
`endif
      bad++;
      $display("FAIL contention_b_count: got %0d grants to B", b_count);
    end
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] d [3];
    logic         exp_re, exp_rv;
    for (int i = 0; i < 3; i++) begin
      d[i] = rnd128();
      preload(6'(i), d[i]);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c < 3) begin req_a = 1'b1; we_a = 1'b0; addr_a = 6'(c); end
      else req_a = 1'b0;
      #3;
      if (c < 3) begin
        total++;
        if (gnt_a !== 1'b1) begin
          bad++;
          $display("FAIL b2b_gnt cycle %0d: gnt_a=%b required 1", c, gnt_a);
        end
      end
      exp_re = (c >= 1 && c <= 3);
      exp_rv = (c >= 2 && c <= 4);
      total++;
      if (read_enable !== exp_re || busy !== exp_re) begin
        bad++;
        $display("FAIL b2b_enable cycle %0d: re=%b busy=%b required %b", c, read_enable, busy, exp_re);
      end
      if (exp_re) begin
        total++;
        if (address !== 6'(c - 1)) begin
          bad++;
          $display("FAIL b2b_addr cycle %0d: addr=%h required %h", c, address, 6'(c - 1));
        end
      end
      total++;
      if (rvalid_a !== exp_rv) begin
        bad++;
        $display("FAIL b2b_rvalid cycle %0d: rv_a=%b required %b", c, rvalid_a, exp_rv);
      end
      if (exp_rv) begin
        total++;
        if (rdata_a !== d[c - 2]) begin
          bad++;
          $display("FAIL b2b_rdata cycle %0d: rd_a=%h required %h", c, rdata_a, d[c - 2]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic         pend_a, pend_b, pwe_a, pwe_b, prio_b;
    logic [5:0]   paddr_a, paddr_b;
    logic [127:0] pwd_a, pwd_b;
    logic         ea, eb, acc_v, acc_we, acc_b, rv_a, rv_b;
    logic [5:0]   acc_addr;
    logic [127:0] acc_wd, acc_rd, hold_a, hold_b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = rnd128();
      preload(6'(i), ref_mem[i]);
    end
    pend_a = 0; pend_b = 0; pwe_a = 0; pwe_b = 0; prio_b = 0;
    paddr_a = '0; paddr_b = '0; pwd_a = '0; pwd_b = '0;
    acc_v = 0; acc_we = 0; acc_b = 0; acc_addr = '0; acc_wd = '0; acc_rd = '0;
    rv_a = 0; rv_b = 0; hold_a = '0; hold_b = '0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (pend_a && $urandom_range(7) == 0) pend_a = 0;
      if (pend_b && $urandom_range(7) == 0) pend_b = 0;
      if (!pend_a && $urandom_range(1) == 1) begin
        pend_a = 1; pwe_a = 1'($urandom_range(1)); paddr_a = 6'($urandom_range(7)); pwd_a = rnd128();
      end
      if (!pend_b && $urandom_range(1) == 1) begin
        pend_b = 1; pwe_b = 1'($urandom_range(1)); paddr_b = 6'($urandom_range(7)); pwd_b = rnd128();
      end
      req_a = pend_a; we_a = pwe_a; addr_a = paddr_a; wdata_a = pwd_a;
      req_b = pend_b; we_b = pwe_b; addr_b = paddr_b; wdata_b = pwd_b;
      #3;
`ifdef SRAM_ARB_RR_EN
      ea = pend_a && (!pend_b || !prio_b);
`else
      ea = pend_a;
`endif
      eb = pend_b && !ea;
      total++;
      if (gnt_a !== ea || gnt_b !== eb) begin
        bad++;
        $display("FAIL rnd_gnt cycle %0d: gnt_a=%b gnt_b=%b required %b %b", c, gnt_a, gnt_b, ea, eb);
      end
      total++;
      if (read_enable !== (acc_v && !acc_we) || write_enable !== (acc_v && acc_we) || busy !== acc_v) begin
        bad++;
        $display("FAIL rnd_enable cycle %0d: re=%b we=%b busy=%b required %b %b %b",
                 c, read_enable, write_enable, busy, acc_v && !acc_we, acc_v && acc_we, acc_v);
      end
      total++;
      if (address !== (acc_v ? acc_addr : 6'd0)) begin
        bad++;
        $display("FAIL rnd_addr cycle %0d: addr=%h required %h", c, address, acc_v ? acc_addr : 6'd0);
      end
      if (!(acc_v && !acc_we)) begin
        total++;
        if (write_data !== (acc_v ? acc_wd : 128'd0)) begin
          bad++;
          $display("FAIL rnd_wdata cycle %0d: wd=%h required %h", c, write_data, acc_v ? acc_wd : 128'd0);
        end
      end
      total++;
      if (rvalid_a !== rv_a || rvalid_b !== rv_b) begin
        bad++;
        $display("FAIL rnd_rvalid cycle %0d: rv_a=%b rv_b=%b required %b %b", c, rvalid_a, rvalid_b, rv_a, rv_b);
      end
      total++;
      if (rdata_a !== hold_a || rdata_b !== hold_b) begin
        bad++;
        $display("FAIL rnd_rdata cycle %0d: rd_a=%h rd_b=%h required %h %h", c, rdata_a, rdata_b, hold_a, hold_b);
      end
      // advance the transaction model by one cycle
      rv_a = acc_v && !acc_we && !acc_b;
      rv_b = acc_v && !acc_we && acc_b;
      if (rv_a) hold_a = acc_rd;
      if (rv_b) hold_b = acc_rd;
      acc_v = ea || eb;
      if (ea) begin acc_b = 0; acc_we = pwe_a; acc_addr = paddr_a; acc_wd = pwd_a; end
      else if (eb) begin acc_b = 1; acc_we = pwe_b; acc_addr = paddr_b; acc_wd = pwd_b; end
      if (acc_v) begin
        if (acc_we) ref_mem[acc_addr[2:0]] = acc_wd;
        else acc_rd = ref_mem[acc_addr[2:0]];
      end
      if (ea) begin pend_a = 0; prio_b = 1; end
      else if (eb) begin pend_b = 0; prio_b = 0; end
    end
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd3;
    #3;
    total++;
    if (gnt_a !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_gnt: gnt_a=%b required 1", gnt_a);
    end
    @(posedge clk); #1;
    n_rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
    #3;
    total++;
    if (read_enable !== 1'b1 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_inflight: re=%b gnt_a=%b gnt_b=%b required 1 0 0", read_enable, gnt_a, gnt_b);
    end
    @(posedge clk); #1;
    total++;
    if ({read_enable, write_enable, rvalid_a, rvalid_b, busy} !== 5'b0 ||
        rdata_a !== 128'd0 || rdata_b !== 128'd0 || address !== 6'd0) begin
      bad++;
      $display("FAIL rstmid_cleared: re=%b we=%b rv_a=%b rv_b=%b busy=%b rd_a=%h rd_b=%h addr=%h required all 0",
               read_enable, write_enable, rvalid_a, rvalid_b, busy, rdata_a, rdata_b, address);
    end
    n_rst = 1'b1;
    #3;
    total++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_first_gnt: gnt_a=%b gnt_b=%b required 1 0", gnt_a, gnt_b);
    end
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    n_rst = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
